ctrl_pipe_chain: RTL and testbench

CTRL_PIPE_CHAIN -- requirements
Module: ctrl_pipe_chain

---
 rtl/ctrl_pipe_chain.sv | 118 +++++++++++
 tb/tb_ctrl_pipe_chain.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: cascade of control-word pipeline registers with
// per-stage stall/flush, automatic bubble insertion behind a stalled
// stage, and saturating stall/flush statistics counters.
module ctrl_pipe_chain #(
  parameter int               WIDTH      = 5,
  parameter int               STAGES     = 2,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int               CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_ctrl,
  input  logic                      in_valid,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  input  logic                      cnt_clr,
  output logic [STAGES*WIDTH-1:0]   out_ctrl,
  output logic [STAGES-1:0]         out_valid,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  logic [WIDTH-1:0]  word_q [STAGES];
  logic [WIDTH-1:0]  word_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_d;

  logic [STAGES-1:0] hold;
  logic [WIDTH-1:0]  feed_word [STAGES];
  logic [STAGES-1:0] feed_valid;
  logic [STAGES-1:0] feed_hold;

  // Effective hold: a stage freezes if it or any stage downstream of it stalls.
  always_comb begin
    hold = '0;
    for (int i = 0; i < STAGES; i++) begin
      hold[i] = |(stall >> i);
    end
  end

  // What each stage would capture: stage 0 sees the input port, later
  // stages see their predecessor. Stage 0 has no upstream hold, so it never
  // takes the bubble path.
  always_comb begin
    feed_word[0]  = in_ctrl;
    feed_valid[0] = in_valid;
    feed_hold[0]  = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      feed_word[i]  = word_q[i-1];
      feed_valid[i] = valid_q[i-1];
      feed_hold[i]  = hold[i-1];
    end
  end

  // Per-stage next state: flush beats hold, hold beats bubble, bubble beats load.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      word_d[i]  = feed_word[i];
      valid_d[i] = feed_valid[i];
      if (flush[i]) begin
        word_d[i]  = BUBBLE_VAL;
        valid_d[i] = 1'b0;
      end else if (hold[i]) begin
        word_d[i]  = word_q[i];
        valid_d[i] = valid_q[i];
      end else if (feed_hold[i]) begin
        // Upstream is frozen but this stage drains: fill the gap with a bubble.
        word_d[i]  = BUBBLE_VAL;
        valid_d[i] = 1'b0;
      end
    end
  end

  // Saturating event counters; a clear wins over a same-cycle increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((|stall) && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if ((|flush) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset to bubbles and zeroed counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) word_q[i] <= BUBBLE_VAL;
      valid_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) word_q[i] <= word_d[i];
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Flatten stage registers onto the output bus; no logic between flop and port.
  always_comb begin
    out_ctrl = '0;
    for (int i = 0; i < STAGES; i++) begin
      out_ctrl[i*WIDTH +: WIDTH] = word_q[i];
    end
  end

  assign out_valid = valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Scoreboard bench for ctrl_pipe_chain: the stimulus process advances a
// behavioural model and queues the expected post-edge state; the monitor
// compares the DUT against the queue after every rising edge.
module tb_ctrl_pipe_chain;
  localparam int             S  = 3;
  localparam int             W  = 5;
  localparam int             CW = 3;
  localparam logic [W-1:0]   BV = 5'h11;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [W-1:0]     in_ctrl = '0;
  logic             in_valid = 1'b0;
  logic [S-1:0]     stall = '0;
  logic [S-1:0]     flush = '0;
  logic             cnt_clr = 1'b0;
  logic [S*W-1:0]   out_ctrl;
  logic [S-1:0]     out_valid;
  logic [CW-1:0]    stall_cnt;
  logic [CW-1:0]    flush_cnt;

  ctrl_pipe_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_VAL(BV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_ctrl(in_ctrl), .in_valid(in_valid),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .out_ctrl(out_ctrl), .out_valid(out_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [S*W-1:0] ctrl;
    logic [S-1:0]   valid;
    logic [CW-1:0]  scnt;
    logic [CW-1:0]  fcnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_w [S];
  logic         m_v [S];
  int           m_sc = 0;
  int           m_fc = 0;
  localparam int CMAX = (1 << CW) - 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model to the state expected after the next edge.
  task automatic drive(input logic rst, input logic [W-1:0] ic, input logic iv,
                       input logic [S-1:0] st, input logic [S-1:0] fl, input logic clr);
    logic [W-1:0] nw [S];
    logic         nv [S];
    logic         frozen [S];
    exp_t e;
    @(negedge clk);
    reset = rst; in_ctrl = ic; in_valid = iv; stall = st; flush = fl; cnt_clr = clr;
    for (int i = 0; i < S; i++) begin
      frozen[i] = 1'b0;
      for (int j = i; j < S; j++) if (st[j]) frozen[i] = 1'b1;
    end
    for (int i = 0; i < S; i++) begin
      if (rst || fl[i])              begin nw[i] = BV;       nv[i] = 1'b0;     end
      else if (frozen[i])            begin nw[i] = m_w[i];   nv[i] = m_v[i];   end
      else if (i == 0)               begin nw[i] = ic;       nv[i] = iv;       end
      else if (frozen[i-1])          begin nw[i] = BV;       nv[i] = 1'b0;     end
      else                           begin nw[i] = m_w[i-1]; nv[i] = m_v[i-1]; end
    end
    for (int i = 0; i < S; i++) begin m_w[i] = nw[i]; m_v[i] = nv[i]; end
    if (rst || clr) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (st != 0 && m_sc < CMAX) m_sc++;
      if (fl != 0 && m_fc < CMAX) m_fc++;
    end
    for (int i = 0; i < S; i++) begin
      e.ctrl[i*W +: W] = m_w[i];
      e.valid[i]       = m_v[i];
    end
    e.scnt = CW'(m_sc);
    e.fcnt = CW'(m_fc);
    q.push_back(e);
  endtask

  // Monitor: every edge the DUT presents a full new state; compare against the queue head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_ctrl",  32'(out_ctrl),  32'(e.ctrl));
      chk("out_valid", 32'(out_valid), 32'(e.valid));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.fcnt));
    end
  end

  initial begin
    logic [S-1:0] rs, rf;
    // Reset
    drive(1, 5'h00, 0, '0, '0, 0);
    drive(1, 5'h1F, 1, 3'b111, 3'b111, 1);
    // Straight flow, one word per cycle, including an invalid word kept as-is
    drive(0, 5'h1B, 1, '0, '0, 0);
    drive(0, 5'h07, 0, '0, '0, 0);
    drive(0, 5'h0C, 1, '0, '0, 0);
    drive(0, 5'h00, 0, '0, '0, 0);
    // Upstream stall: 0A held in stage 0, bubbles go down the chain
    drive(0, 5'h0A, 1, '0, '0, 0);
    drive(0, 5'h13, 1, 3'b001, '0, 0);
    drive(0, 5'h14, 1, 3'b001, '0, 0);
    drive(0, 5'h05, 1, '0, '0, 0);
    drive(0, 5'h06, 1, '0, '0, 0);
    // Downstream stall freezes everything, input ignored
    for (int k = 0; k < 3; k++) drive(0, W'($urandom), 1, 3'b100, '0, 0);
    // Middle-stage stall: stages 0,1 frozen, stage 2 takes bubble
    drive(0, 5'h09, 1, 3'b010, '0, 0);
    // Flush over stall
    drive(0, 5'h15, 1, '0, '0, 0);
    drive(0, 5'h02, 1, 3'b111, 3'b001, 0);
    drive(0, 5'h03, 1, 3'b111, '0, 0);
    // Flush stage 1 while stage 2 stalls
    drive(0, 5'h04, 1, 3'b100, 3'b010, 0);
    // Counter saturation and clear overriding increment
    for (int k = 0; k < 9; k++) drive(0, 5'h08, 1, 3'b100, 3'b001, 0);
    drive(0, 5'h08, 1, 3'b100, 3'b100, 1);
    drive(0, 5'h0E, 1, '0, '0, 0);
    drive(0, 5'h0F, 1, '0, '0, 0);
    drive(0, 5'h10, 1, '0, '0, 0);
    // Reset mid-stream with stalls pending, then immediate load
    drive(1, 5'h1D, 1, 3'b111, 3'b010, 0);
    drive(0, 5'h1E, 1, '0, '0, 0);
    drive(0, 5'h01, 1, '0, '0, 0);
    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rs = '0; rf = '0;
      for (int b = 0; b < S; b++) begin
        rs[b] = ($urandom_range(0, 99) < 15);
        rf[b] = ($urandom_range(0, 99) < 8);
      end
      drive(($urandom_range(0, 99) < 2), W'($urandom), 1'($urandom), rs, rf,
            ($urandom_range(0, 99) < 4));
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
